// File: rtl/calc_pkg.sv
// Shared calculator definitions: matrix geometry, scanner states and keycode helpers.
package calc_pkg;

  localparam int unsigned NUM_ROWS  = 4;
  localparam int unsigned NUM_COLS  = 5;
  localparam int unsigned KEYCODE_W = 5;
  localparam int unsigned ROW_W     = 2;
  localparam int unsigned COL_W     = 3;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD,
    RELEASE
  } scan_state_e;

  // Keycode numbering is 4*col + row, so key 0 is col 0/row 0 and key 19 is col 4/row 3.
  localparam logic [KEYCODE_W-1:0] KEY_FIRST = 5'd0;
  localparam logic [KEYCODE_W-1:0] KEY_LAST  = 5'd19;

  function automatic logic [KEYCODE_W-1:0] make_keycode(input logic [COL_W-1:0] col,
                                                        input logic [ROW_W-1:0] row);
    // With four rows, concatenation is exactly 4*col + row.
    return {col, row};
  endfunction

  function automatic logic [ROW_W-1:0] lowest_low_row(input logic [NUM_ROWS-1:0] r);
    logic [ROW_W-1:0] idx;
    idx = '0;
    for (int i = NUM_ROWS - 1; i >= 0; i--) begin
      if (!r[i]) idx = ROW_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs, parameterised width and reset value.
module sync_2ff #(
  parameter int unsigned          WIDTH     = 1,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// Scans a 4x5 active-low key matrix one column at a time, debounces press and release,
// and emits one newkey strobe with keycode per accepted press.
module keypad_scanner
  import calc_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES   = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_ROWS-1:0]  rows,
  output logic [NUM_COLS-1:0]  cols,
  output logic                 newkey,
  output logic [KEYCODE_W-1:0] keycode
);

  localparam int unsigned SET_W = $clog2(SETTLE_CYCLES) + 1;
  localparam int unsigned DEB_W = $clog2(DEBOUNCE_CYCLES) + 1;

  localparam logic [SET_W-1:0] SETTLE_MAX = SET_W'(SETTLE_CYCLES);
  localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [COL_W-1:0] COL_LAST   = COL_W'(NUM_COLS - 1);

  logic [NUM_ROWS-1:0] rows_s;

  scan_state_e          state_q, state_d;
  logic [COL_W-1:0]     col_idx_q, col_idx_d;
  logic [SET_W-1:0]     settle_q, settle_d;
  logic [DEB_W-1:0]     deb_q, deb_d;
  logic [NUM_ROWS-1:0]  cap_rows_q, cap_rows_d;
  logic [ROW_W-1:0]     cap_row_q, cap_row_d;
  logic                 newkey_q, newkey_d;
  logic [KEYCODE_W-1:0] keycode_q, keycode_d;

  logic                 any_low;
  logic [COL_W-1:0]     col_next;

  sync_2ff #(
    .WIDTH     (NUM_ROWS),
    .RESET_VAL ({NUM_ROWS{1'b1}})
  ) u_rows_sync (
    .clock (clock),
    .reset (reset),
    .d     (rows),
    .q     (rows_s)
  );

  always_comb begin
    any_low  = ~&rows_s;
    col_next = (col_idx_q == COL_LAST) ? '0 : col_idx_q + 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    col_idx_d  = col_idx_q;
    settle_d   = settle_q;
    deb_d      = deb_q;
    cap_rows_d = cap_rows_q;
    cap_row_d  = cap_row_q;
    newkey_d   = 1'b0;
    keycode_d  = keycode_q;

    unique case (state_q)
      SCAN: begin
        if (settle_q < SETTLE_MAX) begin
          settle_d = settle_q + 1'b1;
        end else if (any_low) begin
          cap_rows_d = rows_s;
          cap_row_d  = lowest_low_row(rows_s);
          deb_d      = '0;
          state_d    = DEBOUNCE;
        end else begin
          col_idx_d = col_next;
          settle_d  = '0;
        end
      end
      DEBOUNCE: begin
        // Any change in the row pattern, including a second key, restarts detection.
        if (rows_s != cap_rows_q) begin
          settle_d = '0;
          state_d  = SCAN;
        end else if (deb_q >= DEB_LAST) begin
          newkey_d  = 1'b1;
          keycode_d = make_keycode(col_idx_q, cap_row_q);
          state_d   = HELD;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end
      HELD: begin
        if (!any_low) begin
          deb_d   = '0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (any_low) begin
          state_d = HELD;
        end else if (deb_q >= DEB_LAST) begin
          col_idx_d = col_next;
          settle_d  = '0;
          state_d   = SCAN;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= SCAN;
      col_idx_q  <= '0;
      settle_q   <= '0;
      deb_q      <= '0;
      cap_rows_q <= '1;
      cap_row_q  <= '0;
      newkey_q   <= 1'b0;
      keycode_q  <= '0;
    end else begin
      state_q    <= state_d;
      col_idx_q  <= col_idx_d;
      settle_q   <= settle_d;
      deb_q      <= deb_d;
      cap_rows_q <= cap_rows_d;
      cap_row_q  <= cap_row_d;
      newkey_q   <= newkey_d;
      keycode_q  <= keycode_d;
    end
  end

  always_comb begin
    cols    = ~(NUM_COLS'(1) << col_idx_q);
    newkey  = newkey_q;
    keycode = keycode_q;
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a behavioural key matrix drives rows from cols.
module tb_keypad_scanner;

  logic       clock;
  logic       reset;
  logic [3:0] rows;
  logic [4:0] cols;
  logic       newkey;
  logic [4:0] keycode;

  logic [19:0] keys;  // keys[4*col+row] = physically pressed

  int unsigned n_cmp;
  int unsigned n_err;
  int unsigned cyc;
  int unsigned base;
  int unsigned nk_count;
  int unsigned nk_ref;
  int unsigned consec;
  int unsigned last_nk_cyc;
  logic [4:0]  last_code;
  logic        prev_nk;
  logic [4:0]  exp_cols;
  logic        found;

  keypad_scanner #(
    .SETTLE_CYCLES   (4),
    .DEBOUNCE_CYCLES (16)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .rows    (rows),
    .cols    (cols),
    .newkey  (newkey),
    .keycode (keycode)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Passive matrix: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    rows = 4'hF;
    for (int c = 0; c < 5; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (keys[4*c+r] && !cols[c]) rows[r] = 1'b0;
      end
    end
  end

  initial begin
    nk_count    = 0;
    consec      = 0;
    last_nk_cyc = 0;
    last_code   = '0;
    prev_nk     = 1'b0;
  end

  always @(posedge clock) begin
    #1;
    if (newkey === 1'b1) begin
      if (prev_nk) consec++;
      nk_count++;
      last_code   = keycode;
      last_nk_cyc = cyc;
    end
    prev_nk = (newkey === 1'b1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    base  = cyc;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    keys  = '0;

    // Reset state and free-running column rotation, 5 cycles per column.
    do_reset();
    check_eq("reset_cols", cols, 5'b11110);
    check_eq("reset_newkey", newkey, 0);
    check_eq("reset_keycode", keycode, 0);
    for (int i = 1; i <= 25; i++) begin
      step(1);
      exp_cols = 5'b11111 ^ (5'b00001 << ((i / 5) % 5));
      check_eq("scan_rotate", cols, exp_cols);
    end

    // Single press of key 9: col 2 goes active 10 edges after reset, strobe 21 edges later.
    do_reset();
    nk_ref  = nk_count;
    keys[9] = 1'b1;
    step(30);
    check_eq("k9_not_early", nk_count, nk_ref);
    step(1);
    check_eq("k9_strobe", newkey, 1);
    check_eq("k9_count", nk_count, nk_ref + 1);
    check_eq("k9_latency", last_nk_cyc - base, 31);
    check_eq("k9_keycode", keycode, 9);
    step(1);
    check_eq("k9_one_cycle", newkey, 0);
    check_eq("k9_code_held", keycode, 9);
    step(150);
    check_eq("k9_hold_cols", cols, 5'b11011);
    check_eq("k9_hold_count", nk_count, nk_ref + 1);
    keys[9] = 1'b0;
    step(18);
    check_eq("k9_release_held", cols, 5'b11011);
    step(1);
    check_eq("k9_release_adv", cols, 5'b10111);

    // Bouncing key 0: 10-cycle toggles never give 16 stable cycles.
    do_reset();
    nk_ref = nk_count;
    for (int i = 0; i < 10; i++) begin
      keys[0] = ~keys[0];
      step(10);
    end
    keys[0] = 1'b0;
    step(60);
    check_eq("bounce_no_key", nk_count, nk_ref);

    // Long hold of key 19, then release with three short re-closures.
    do_reset();
    nk_ref   = nk_count;
    keys[19] = 1'b1;
    step(1000);
    check_eq("k19_count", nk_count, nk_ref + 1);
    check_eq("k19_keycode", last_code, 19);
    for (int i = 0; i < 3; i++) begin
      keys[19] = 1'b0;
      step(8);
      keys[19] = 1'b1;
      step(5);
    end
    keys[19] = 1'b0;
    step(18);
    check_eq("k19_col4_held", cols, 5'b01111);
    step(1);
    check_eq("k19_wrap_col0", cols, 5'b11110);
    step(40);
    check_eq("k19_bounce_count", nk_count, nk_ref + 1);
    check_eq("k19_code_kept", keycode, 19);

    // Keys 6 and 7 together on column 1: lowest row wins.
    do_reset();
    nk_ref  = nk_count;
    keys[6] = 1'b1;
    keys[7] = 1'b1;
    step(26);
    check_eq("two_strobe", newkey, 1);
    check_eq("two_latency", last_nk_cyc - base, 26);
    check_eq("two_keycode", keycode, 6);
    step(1);
    check_eq("two_one_cycle", newkey, 0);

    // Reset 8 cycles into DEBOUNCE on key 0 while the key stays down.
    keys[6] = 1'b0;
    keys[7] = 1'b0;
    found   = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      step(1);
      if (cols == 5'b11110) found = 1'b1;
    end
    check_eq("wait_col0", found, 1);
    keys[0] = 1'b1;
    nk_ref  = nk_count;
    step(12);
    check_eq("mid_db_no_key", nk_count, nk_ref);
    reset = 1'b1;
    step(1);
    check_eq("mid_db_rst_cols", cols, 5'b11110);
    check_eq("mid_db_rst_newkey", newkey, 0);
    check_eq("mid_db_rst_keycode", keycode, 0);
    check_eq("mid_db_rst_count", nk_count, nk_ref);
    reset = 1'b0;
    base  = cyc;
    step(20);
    check_eq("redetect_not_early", nk_count, nk_ref);
    step(1);
    check_eq("redetect_strobe", newkey, 1);
    check_eq("redetect_count", nk_count, nk_ref + 1);
    check_eq("redetect_keycode", keycode, 0);
    keys[0] = 1'b0;
    step(40);

    check_eq("no_back_to_back", consec, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
